load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential memory-access engine that executes the load/store operation selected by the control unit's load/store type. It sits between the execute stage and the data memory port. It converts a byte address plus a type into a word-aligned, byte-enabled memory request with a ready/valid handshake. It returns lane-extracted, sign- or zero-extended load data and stalls the core via `o_Busy` until the access retires.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQUEST plus WAIT_READ before the access is aborted with `o_Timeout`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `i_Clock` input, 1: clock; all state changes on rising edge.
- `i_Reset` input, 1: synchronous, active-high reset.
- `i_Start` input, 1: request strobe; sampled only in IDLE.
- `i_Load_Store_Type` input, LS_SEL_WIDTH+1: `LS_TYPE_*` code from `memory.vh`.
- `i_Addr` input, 32: byte address (ALU result).
- `i_Store_Data` input, 32: rs2 value; low byte/half used for SB/SH.
- `o_Busy` output, 1: high in every state except IDLE.
- `o_Done` output, 1: one-cycle retire pulse.
- `o_Load_Data` output, 32: extended load result; held until next retire.
- `o_Misaligned` output, 1: valid with `o_Done`; access was misaligned and not issued.
- `o_Timeout` output, 1: valid with `o_Done`; memory did not respond in time.
- `o_Mem_Req` output, 1: memory request valid.
- `o_Mem_Write_Enable` output, 1: request is a write.
- `o_Mem_Addr` output, 32: `{i_Addr[31:2], 2'b00}`.
- `o_Mem_Byte_Enable` output, 4: lane enables, bit n = bits [8n+7:8n].
- `o_Mem_Write_Data` output, 32: lane-replicated store data.
- `i_Mem_Ready` input, 1: memory accepts the request this cycle.
- `i_Mem_Read_Valid` input, 1: `i_Mem_Read_Data` valid this cycle.
- `i_Mem_Read_Data` input, 32: read word.

## Operation
- States:
  - IDLE: waits for a request.
  - REQUEST: `o_Mem_Req`=1 until `i_Mem_Ready`.
  - WAIT_READ: loads only; waits for `i_Mem_Read_Valid`.
  - DONE: `o_Done`=1 for exactly one cycle, then IDLE.
- IDLE + `i_Start`: latch type, addr[1:0] and store data, then branch:
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0): go to DONE with `o_Misaligned`=1; no memory request.
  - `LS_TYPE_NONE`: go to DONE, `o_Load_Data`=0.
  - Otherwise: go to REQUEST.
- Store lanes:
  - SB: BE=`4'b0001<<a`, data=`{4{d[7:0]}}`.
  - SH: BE=`4'b0011<<a`, data=`{2{d[15:0]}}`.
  - SW: BE=`4'b1111`.
- Loads drive BE=`4'b0000` and `o_Mem_Write_Enable`=0.
- REQUEST + `i_Mem_Ready`: store goes to DONE; load goes to WAIT_READ.
- WAIT_READ + `i_Mem_Read_Valid`: extract lane `i_Mem_Read_Data >> (8*a)`, then:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Register the result into `o_Load_Data` and go to DONE.
- `i_Mem_Read_Valid` outside WAIT_READ is ignored.
- Timeout counter:
  - Cleared on leaving IDLE; increments each cycle in REQUEST/WAIT_READ.
  - On reaching `TIMEOUT_CYCLES`: go to DONE with `o_Timeout`=1. `o_Load_Data` is unchanged; `o_Mem_Req` drops.
- `i_Start` while busy is ignored; the request is not queued.
- Latched operands are used throughout; input changes after acceptance have no effect.

## Timing
- Reset:
  - State = IDLE.
  - Outputs `o_Busy`, `o_Done`, `o_Misaligned`, `o_Timeout`, `o_Mem_Req` and `o_Mem_Write_Enable` = 0.
  - `o_Mem_Addr`, `o_Mem_Byte_Enable`, `o_Mem_Write_Data` and `o_Load_Data` = 0.
  - Counter = 0.
- Reset mid-access: the next cycle is IDLE with all of the above values; the outstanding request is abandoned and a late `i_Mem_Read_Valid` is ignored.
- `i_Start` at cycle N: `o_Busy`=1 and `o_Mem_Req`=1 from N+1.
- Store with `i_Mem_Ready` at N+1: `o_Done` at N+2, IDLE at N+3.
- Load with ready at N+1 and read valid at N+2: `o_Done` and `o_Load_Data` at N+3.
- Misaligned or NONE: `o_Done` at N+1.
- Request outputs are registered and stable while `o_Mem_Req`=1 and `i_Mem_Ready`=0.
- `o_Misaligned` and `o_Timeout` are high only in the DONE cycle; both are 0 otherwise.
- A new `i_Start` is accepted in the IDLE cycle after DONE, giving a minimum of 3 cycles per store.

## Test plan
- SB at addr 0x1003, data 0xA5, ready immediate -> Mem_Addr 0x1000, BE 4'b1000, WData 0xA5A5A5A5, Done at N+2.
- LB at addr 0x2001, read 0x0000_8000 -> Load_Data 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- LH at 0x2002, read 0x8001_1234 -> 0xFFFF_8001. LW with ready held low 5 cycles -> request outputs stable throughout, Done one cycle after read valid.
- SW at 0x3002 -> Done and Misaligned at N+1; `o_Mem_Req` never asserted. LH at 0x3001 -> same.
- `TIMEOUT_CYCLES`=4, `i_Mem_Ready` stuck 0 -> Done with Timeout after 4 REQUEST cycles; `o_Load_Data` keeps its previous value.
- Reset asserted in WAIT_READ, then read valid 0xDEADBEEF -> IDLE with all outputs 0; no Done, `o_Load_Data` stays 0. `i_Start` while busy is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store engine: turns a byte address and access type into a word-aligned,
// byte-enabled memory request, and returns lane-extracted, extended load data.
module load_store_unit #(
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int LS_SEL_WIDTH   = 3
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Start,
  input  logic [LS_SEL_WIDTH:0]   i_Load_Store_Type,
  input  logic [31:0]             i_Addr,
  input  logic [31:0]             i_Store_Data,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic [31:0]             o_Load_Data,
  output logic                    o_Misaligned,
  output logic                    o_Timeout,
  output logic                    o_Mem_Req,
  output logic                    o_Mem_Write_Enable,
  output logic [31:0]             o_Mem_Addr,
  output logic [3:0]              o_Mem_Byte_Enable,
  output logic [31:0]             o_Mem_Write_Data,
  input  logic                    i_Mem_Ready,
  input  logic                    i_Mem_Read_Valid,
  input  logic [31:0]             i_Mem_Read_Data
);

  localparam logic [3:0] LS_TYPE_NONE = 4'd0;
  localparam logic [3:0] LS_TYPE_LB   = 4'd1;
  localparam logic [3:0] LS_TYPE_LH   = 4'd2;
  localparam logic [3:0] LS_TYPE_LW   = 4'd3;
  localparam logic [3:0] LS_TYPE_LBU  = 4'd4;
  localparam logic [3:0] LS_TYPE_LHU  = 4'd5;
  localparam logic [3:0] LS_TYPE_SB   = 4'd6;
  localparam logic [3:0] LS_TYPE_SH   = 4'd7;
  localparam logic [3:0] LS_TYPE_SW   = 4'd8;

  localparam int             CW           = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQUEST   = 2'd1,
    ST_WAIT_READ = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t                 state_r;
  logic [LS_SEL_WIDTH:0]  type_r;
  logic [1:0]             offset_r;
  logic [CW-1:0]          count_r;

  function automatic logic is_store(input logic [3:0] t);
    return (t == LS_TYPE_SB) || (t == LS_TYPE_SH) || (t == LS_TYPE_SW);
  endfunction

  // Unknown codes are retired like NONE so a corrupted type never reaches memory.
  function automatic logic is_nop(input logic [3:0] t);
    return (t == LS_TYPE_NONE) || (t > LS_TYPE_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] t, input logic [1:0] a);
    case (t)
      LS_TYPE_LH, LS_TYPE_LHU, LS_TYPE_SH: is_misaligned = a[0];
      LS_TYPE_LW, LS_TYPE_SW:              is_misaligned = (a != 2'b00);
      default:                             is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [3:0] t, input logic [1:0] a);
    case (t)
      LS_TYPE_SB: store_be = 4'b0001 << a;
      LS_TYPE_SH: store_be = 4'b0011 << a;
      LS_TYPE_SW: store_be = 4'b1111;
      default:    store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] t, input logic [31:0] d);
    case (t)
      LS_TYPE_SB: store_data = {4{d[7:0]}};
      LS_TYPE_SH: store_data = {2{d[15:0]}};
      LS_TYPE_SW: store_data = d;
      default:    store_data = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] t, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [31:0] lane;
    lane = w >> {a, 3'b000};
    case (t)
      LS_TYPE_LB:  load_extend = {{24{lane[7]}}, lane[7:0]};
      LS_TYPE_LBU: load_extend = {24'd0, lane[7:0]};
      LS_TYPE_LH:  load_extend = {{16{lane[15]}}, lane[15:0]};
      LS_TYPE_LHU: load_extend = {16'd0, lane[15:0]};
      LS_TYPE_LW:  load_extend = lane;
      default:     load_extend = 32'd0;
    endcase
  endfunction

  // Access sequencer: state, latched operands, timeout counter and all registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r            <= ST_IDLE;
      type_r             <= 4'd0;
      offset_r           <= 2'b00;
      count_r            <= '0;
      o_Busy             <= 1'b0;
      o_Done             <= 1'b0;
      o_Load_Data        <= 32'd0;
      o_Misaligned       <= 1'b0;
      o_Timeout          <= 1'b0;
      o_Mem_Req          <= 1'b0;
      o_Mem_Write_Enable <= 1'b0;
      o_Mem_Addr         <= 32'd0;
      o_Mem_Byte_Enable  <= 4'b0000;
      o_Mem_Write_Data   <= 32'd0;
    end else begin
      o_Done       <= 1'b0;
      o_Misaligned <= 1'b0;
      o_Timeout    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_Start) begin
            type_r   <= i_Load_Store_Type;
            offset_r <= i_Addr[1:0];
            count_r  <= '0;
            o_Busy   <= 1'b1;
            if (is_misaligned(i_Load_Store_Type, i_Addr[1:0])) begin
              state_r      <= ST_DONE;
              o_Done       <= 1'b1;
              o_Misaligned <= 1'b1;
            end else if (is_nop(i_Load_Store_Type)) begin
              state_r     <= ST_DONE;
              o_Done      <= 1'b1;
              o_Load_Data <= 32'd0;
            end else begin
              state_r            <= ST_REQUEST;
              o_Mem_Req          <= 1'b1;
              o_Mem_Write_Enable <= is_store(i_Load_Store_Type);
              o_Mem_Addr         <= {i_Addr[31:2], 2'b00};
              o_Mem_Byte_Enable  <= store_be(i_Load_Store_Type, i_Addr[1:0]);
              o_Mem_Write_Data   <= store_data(i_Load_Store_Type, i_Store_Data);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQUEST: begin
          if (i_Mem_Ready) begin
            o_Mem_Req          <= 1'b0;
            o_Mem_Write_Enable <= 1'b0;
            count_r            <= count_r + CW'(1);
            if (is_store(type_r)) begin
              state_r <= ST_DONE;
              o_Done  <= 1'b1;
            end else begin
              state_r <= ST_WAIT_READ;
            end
          end else if (count_r >= TIMEOUT_LAST) begin
            state_r            <= ST_DONE;
            o_Done             <= 1'b1;
            o_Timeout          <= 1'b1;
            o_Mem_Req          <= 1'b0;
            o_Mem_Write_Enable <= 1'b0;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        ST_WAIT_READ: begin
          if (i_Mem_Read_Valid) begin
            state_r     <= ST_DONE;
            o_Done      <= 1'b1;
            o_Load_Data <= load_extend(type_r, offset_r, i_Mem_Read_Data);
          end else if (count_r >= TIMEOUT_LAST) begin
            state_r   <= ST_DONE;
            o_Done    <= 1'b1;
            o_Timeout <= 1'b1;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          o_Busy  <= 1'b0;
        end
        default: begin
          state_r            <= ST_IDLE;
          o_Busy             <= 1'b0;
          o_Mem_Req          <= 1'b0;
          o_Mem_Write_Enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected retire and
// request records; negedge monitors pop and compare whenever the DUT presents them.
module tb_load_store_unit;

  localparam logic [3:0] LS_NONE = 4'd0;
  localparam logic [3:0] LS_LB   = 4'd1;
  localparam logic [3:0] LS_LH   = 4'd2;
  localparam logic [3:0] LS_LW   = 4'd3;
  localparam logic [3:0] LS_LBU  = 4'd4;
  localparam logic [3:0] LS_LHU  = 4'd5;
  localparam logic [3:0] LS_SB   = 4'd6;
  localparam logic [3:0] LS_SH   = 4'd7;
  localparam logic [3:0] LS_SW   = 4'd8;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        mis;
    logic        tmo;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  logic        clk = 1'b0;
  logic        rst, start, t_start, mem_ready, t_ready, rvalid;
  logic [3:0]  ls_type;
  logic [31:0] addr, sdata, rdata;

  logic        busy, done, mis, tmo, req, we;
  logic [31:0] ldata, maddr, wdata;
  logic [3:0]  be;
  logic        t_busy, t_done, t_mis, t_tmo, t_req, t_we;
  logic [31:0] t_ldata, t_maddr, t_wdata;
  logic [3:0]  t_be;

  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  logic [31:0] exp_ld = 32'd0;
  done_t done_q[$];
  done_t tdone_q[$];
  req_t  req_q[$];

  logic        prev_stall = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  logic        p_we;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit dut (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Load_Store_Type(ls_type),
    .i_Addr(addr), .i_Store_Data(sdata), .o_Busy(busy), .o_Done(done),
    .o_Load_Data(ldata), .o_Misaligned(mis), .o_Timeout(tmo), .o_Mem_Req(req),
    .o_Mem_Write_Enable(we), .o_Mem_Addr(maddr), .o_Mem_Byte_Enable(be),
    .o_Mem_Write_Data(wdata), .i_Mem_Ready(mem_ready), .i_Mem_Read_Valid(rvalid),
    .i_Mem_Read_Data(rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .i_Clock(clk), .i_Reset(rst), .i_Start(t_start), .i_Load_Store_Type(ls_type),
    .i_Addr(addr), .i_Store_Data(sdata), .o_Busy(t_busy), .o_Done(t_done),
    .o_Load_Data(t_ldata), .o_Misaligned(t_mis), .o_Timeout(t_tmo), .o_Mem_Req(t_req),
    .o_Mem_Write_Enable(t_we), .o_Mem_Addr(t_maddr), .o_Mem_Byte_Enable(t_be),
    .o_Mem_Write_Data(t_wdata), .i_Mem_Ready(t_ready), .i_Mem_Read_Valid(rvalid),
    .i_Mem_Read_Data(rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Retire monitor for the main instance, plus request handshake and stability checks.
  always @(negedge clk) begin
    if (done) begin
      if (done_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        chk("done_cycle", cyc, done_q[0].cyc);
        chk("load_data", ldata, done_q[0].data);
        chk("misaligned", {31'd0, mis}, {31'd0, done_q[0].mis});
        chk("timeout", {31'd0, tmo}, {31'd0, done_q[0].tmo});
        done_q.delete(0);
      end
    end else if (mis || tmo) begin
      chk("flags_outside_done", {30'd0, mis, tmo}, 32'd0);
    end
    if (req && prev_stall) begin
      chk("stable_addr", maddr, p_addr);
      chk("stable_be", {28'd0, be}, {28'd0, p_be});
      chk("stable_wdata", wdata, p_wdata);
      chk("stable_we", {31'd0, we}, {31'd0, p_we});
    end
    if (req && mem_ready) begin
      if (req_q.size() == 0) begin
        chk("spurious_req", 32'd1, 32'd0);
      end else begin
        chk("req_addr", maddr, req_q[0].addr);
        chk("req_be", {28'd0, be}, {28'd0, req_q[0].be});
        chk("req_wdata", wdata, req_q[0].wdata);
        chk("req_we", {31'd0, we}, {31'd0, req_q[0].we});
        req_q.delete(0);
      end
    end
    prev_stall <= req && !mem_ready;
    p_addr     <= maddr;
    p_be       <= be;
    p_wdata    <= wdata;
    p_we       <= we;
  end

  // Retire monitor for the short-timeout instance.
  always @(negedge clk) begin
    if (t_done) begin
      if (tdone_q.size() == 0) begin
        chk("t_spurious_done", 32'd1, 32'd0);
      end else begin
        chk("t_done_cycle", cyc, tdone_q[0].cyc);
        chk("t_load_data", t_ldata, tdone_q[0].data);
        chk("t_misaligned", {31'd0, t_mis}, {31'd0, tdone_q[0].mis});
        chk("t_timeout", {31'd0, t_tmo}, {31'd0, tdone_q[0].tmo});
        chk("t_req_dropped", {31'd0, t_req}, 32'd0);
        tdone_q.delete(0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input bit sel);
    for (int i = 0; i < 300; i++) begin
      if (!(sel ? t_busy : busy)) return;
      tick();
    end
    chk(sel ? "t_idle_wait_expired" : "idle_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic issue(input bit sel, input logic [3:0] t, input logic [31:0] a,
                       input logic [31:0] d);
    if (sel) t_start = 1'b1;
    else     start = 1'b1;
    ls_type = t;
    addr    = a;
    sdata   = d;
    tick();
    start   = 1'b0;
    t_start = 1'b0;
  endtask

  task automatic do_store(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int n;
    n = cyc;
    req_q.push_back('{a & ~32'd3, exp_be, exp_wd, 1'b1});
    done_q.push_back('{n + 2, exp_ld, 1'b0, 1'b0});
    issue(1'b0, t, a, d);
    chk("busy_req_n1", {30'd0, busy, req}, 32'd3);
    wait_idle(1'b0);
  endtask

  task automatic do_load(input logic [3:0] t, input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp);
    int n;
    n = cyc;
    req_q.push_back('{a & ~32'd3, 4'b0000, 32'd0, 1'b0});
    done_q.push_back('{n + 3, exp, 1'b0, 1'b0});
    issue(1'b0, t, a, 32'hFFFF_FFFF);
    tick();
    rvalid = 1'b1;
    rdata  = rd;
    tick();
    rvalid = 1'b0;
    exp_ld = exp;
    wait_idle(1'b0);
  endtask

  task automatic do_reject(input logic [3:0] t, input logic [31:0] a, input logic exp_mis,
                           input logic [31:0] exp_data);
    int n;
    n = cyc;
    done_q.push_back('{n + 1, exp_data, exp_mis, 1'b0});
    issue(1'b0, t, a, 32'h1234_5678);
    exp_ld = exp_data;
    wait_idle(1'b0);
  endtask

  task automatic check_zero;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_load_data", ldata, 32'd0);
    chk("rst_flags", {30'd0, mis, tmo}, 32'd0);
    chk("rst_req_we", {30'd0, req, we}, 32'd0);
    chk("rst_mem_addr", maddr, 32'd0);
    chk("rst_be", {28'd0, be}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; t_start = 1'b0; mem_ready = 1'b1; t_ready = 1'b1;
    rvalid = 1'b0; rdata = 32'd0; ls_type = LS_NONE; addr = 32'd0; sdata = 32'd0;
    tick(3);
    rst = 1'b0;
    check_zero();
    chk("t_rst_outputs", {t_busy, t_done, t_req, t_we, t_mis, t_tmo, t_be, 22'd0},
        32'd0);

    do_store(LS_SB, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_store(LS_SH, 32'h0000_1002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_store(LS_SW, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    do_store(LS_SB, 32'h0000_1001, 32'h0000_0042, 4'b0010, 32'h4242_4242);
    do_load(LS_LB,  32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
    do_load(LS_LBU, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
    do_load(LS_LH,  32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001);
    do_load(LS_LHU, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001);
    do_load(LS_LB,  32'h0000_2003, 32'h7F00_00FF, 32'h0000_007F);

    // LW with ready held low for five cycles; a busy start and operand changes must be ignored.
    begin
      int n;
      n = cyc;
      mem_ready = 1'b0;
      req_q.push_back('{32'h0000_4000, 4'b0000, 32'd0, 1'b0});
      done_q.push_back('{n + 8, 32'h1234_5678, 1'b0, 1'b0});
      issue(1'b0, LS_LW, 32'h0000_4000, 32'd0);
      start = 1'b1; ls_type = LS_SB; addr = 32'h0000_5555; sdata = 32'h0000_0077;
      tick();
      start = 1'b0;
      tick(4);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      rvalid = 1'b1; rdata = 32'h1234_5678;
      tick();
      rvalid = 1'b0;
      mem_ready = 1'b1;
      exp_ld = 32'h1234_5678;
      wait_idle(1'b0);
    end

    do_reject(LS_SW, 32'h0000_3002, 1'b1, exp_ld);
    do_reject(LS_LH, 32'h0000_3001, 1'b1, exp_ld);
    do_reject(LS_NONE, 32'h0000_3000, 1'b0, 32'd0);
    do_load(LS_LW, 32'h0000_2000, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

    // Reset while waiting for read data; the late read valid must not retire anything.
    req_q.push_back('{32'h0000_6000, 4'b0000, 32'd0, 1'b0});
    issue(1'b0, LS_LW, 32'h0000_6000, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    tick(2);
    chk("post_rst_load_data", ldata, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Short-timeout instance: prime load data, then let a request go unanswered.
    begin
      int n;
      n = cyc;
      t_ready = 1'b1;
      tdone_q.push_back('{n + 3, 32'h0000_0080, 1'b0, 1'b0});
      issue(1'b1, LS_LBU, 32'h0000_2001, 32'd0);
      tick();
      rvalid = 1'b1; rdata = 32'h0000_8000;
      tick();
      rvalid = 1'b0;
      wait_idle(1'b1);
      n = cyc;
      t_ready = 1'b0;
      tdone_q.push_back('{n + 5, 32'h0000_0080, 1'b0, 1'b1});
      issue(1'b1, LS_LW, 32'h0000_2000, 32'd0);
      wait_idle(1'b1);
    end

    tick(2);
    chk("done_q_drained", done_q.size(), 32'd0);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("tdone_q_drained", tdone_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
